// File: rtl/uart_receiver.sv
// uart_receiver: 8N1 serial receiver with a two-flop input synchronizer.
// The bit period is CLKS_PER_BIT clocks. The start bit is checked at its midpoint.
// Each data bit and the stop bit are then sampled one full period later, near its centre.
// A good frame updates data_out and pulses data_valid for one clock.
// A frame whose stop bit samples low pulses frame_err for one clock and leaves data_out unchanged.
module uart_receiver #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       data_valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);

  // Mid-start-bit sample point and full-bit sample point.
  localparam logic [CNT_W-1:0] HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] START = 2'd1;
  localparam logic [1:0] DATA  = 2'd2;
  localparam logic [1:0] STOP  = 2'd3;

  logic             rx_m;
  logic             rx_s;
  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       bit_idx;
  logic [7:0]       shift;

  // Two-flop synchronizer; flops reset to the idle (high) line level.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= rx;
      rx_s <= rx_m;
    end
  end

  // Frame FSM: start detection, bit sampling, stop check and output pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      bit_idx    <= 3'd0;
      shift      <= 8'hFF;
      data_out   <= 8'hFF;
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (!rx_s) begin
            state <= START;
          end
        end
        START: begin
          if (cnt == HALF_M1) begin
            cnt <= '0;
            // A line that is high again at mid-start was a glitch.
            state <= rx_s ? IDLE : DATA;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt == FULL_M1) begin
            shift[bit_idx] <= rx_s;
            cnt            <= '0;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt == FULL_M1) begin
            cnt <= '0;
            if (rx_s) begin
              data_out   <= shift;
              data_valid <= 1'b1;
            end else begin
              frame_err <= 1'b1;
            end
            state <= IDLE;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: directed frames and a scoreboard of expected output pulses.
module tb_uart_receiver;

  localparam int CPB = 16;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
  } exp_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx = 1'b1;
  logic [7:0] data_out;
  logic       data_valid;
  logic       frame_err;
  logic       busy;

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   dv_cnt = 0;
  int   fe_cnt = 0;
  int   busy_run = 0;
  int   last_run = 0;
  int   dv_times[$];
  exp_t sb[$];
  exp_t mon_e;
  logic dv_prev = 1'b0;
  logic fe_prev = 1'b0;
  logic [7:0] model_dout = 8'hFF;

  uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk),
    .reset(reset),
    .rx(rx),
    .data_out(data_out),
    .data_valid(data_valid),
    .frame_err(frame_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Pulse monitor: pops one scoreboard entry per data_valid/frame_err pulse.
  always @(negedge clk) begin
    if (busy) busy_run++;
    else if (busy_run != 0) begin
      last_run = busy_run;
      busy_run = 0;
    end
    if (data_valid || frame_err) begin
      if (data_valid) begin
        dv_cnt++;
        dv_times.push_back(cyc);
      end
      if (frame_err) fe_cnt++;
      check("pulse_exclusive", 32'(data_valid && frame_err), 32'd0);
      check("pulse_one_cycle", 32'((data_valid && dv_prev) || (frame_err && fe_prev)), 32'd0);
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_pulse observed=dv%0b/fe%0b expected=none", data_valid, frame_err);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        check("pulse_kind", 32'(frame_err), 32'(mon_e.is_err));
        check("pulse_data_out", 32'(data_out), 32'(mon_e.data));
      end
    end
    dv_prev = data_valid;
    fe_prev = frame_err;
  end

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(stop);
    rx = 1'b1;
  endtask

  task automatic push_exp(input logic is_err, input logic [7:0] d);
    exp_t e;
    e.is_err = is_err;
    e.data   = d;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (sb.size() != 0 && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    sb.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    model_dout = 8'hFF;
    sb.delete();
  endtask

  initial begin
    int dv0;
    int fe0;

    // Reset state
    apply_reset();
    @(negedge clk);
    check("rst_data_out", 32'(data_out), 32'hFF);
    check("rst_data_valid", 32'(data_valid), 32'd0);
    check("rst_frame_err", 32'(frame_err), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    @(posedge clk);
    #1;

    // Good frame 0x55
    dv0 = dv_cnt; fe0 = fe_cnt;
    push_exp(1'b0, 8'h55); model_dout = 8'h55;
    send_byte(8'h55, 1'b1);
    drain(200);
    check("x55_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("x55_fe_count", 32'(fe_cnt - fe0), 32'd0);
    check("x55_data_out", 32'(data_out), 32'h55);
    check("x55_busy_after", 32'(busy), 32'd0);

    // False start: 4-clock low glitch
    dv0 = dv_cnt; fe0 = fe_cnt; last_run = 0;
    rx = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rx = 1'b1;
    repeat (30) @(posedge clk);
    #1;
    check("glitch_busy_seen", 32'(last_run >= 1), 32'd1);
    check("glitch_busy_le8", 32'(last_run <= 8), 32'd1);
    check("glitch_dv_count", 32'(dv_cnt - dv0), 32'd0);
    check("glitch_fe_count", 32'(fe_cnt - fe0), 32'd0);
    check("glitch_busy_after", 32'(busy), 32'd0);

    // Bad stop bit 0xA3 straight after reset
    apply_reset();
    dv0 = dv_cnt; fe0 = fe_cnt;
    push_exp(1'b1, 8'hFF);
    send_byte(8'hA3, 1'b0);
    drain(200);
    repeat (40) @(posedge clk);
    #1;
    check("a3_fe_count", 32'(fe_cnt - fe0), 32'd1);
    check("a3_dv_count", 32'(dv_cnt - dv0), 32'd0);
    check("a3_data_out_kept", 32'(data_out), 32'hFF);

    // Back-to-back 0x00, 0xFF, 0x81
    dv_times.delete();
    push_exp(1'b0, 8'h00);
    push_exp(1'b0, 8'hFF);
    push_exp(1'b0, 8'h81);
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    send_byte(8'h81, 1'b1);
    model_dout = 8'h81;
    drain(200);
    check("b2b_pulses", 32'(dv_times.size()), 32'd3);
    if (dv_times.size() == 3) begin
      check("b2b_gap1", 32'(dv_times[1] - dv_times[0]), 32'd160);
      check("b2b_gap2", 32'(dv_times[2] - dv_times[1]), 32'd160);
    end
    check("b2b_data_out", 32'(data_out), 32'h81);

    // Reset during DATA of 0x3C, then a clean 0x3C
    dv0 = dv_cnt; fe0 = fe_cnt;
    fork
      send_byte(8'h3C, 1'b1);
      begin
        repeat (135) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
      end
    join
    model_dout = 8'hFF;
    repeat (40) @(posedge clk);
    #1;
    check("abort_dv_count", 32'(dv_cnt - dv0), 32'd0);
    check("abort_fe_count", 32'(fe_cnt - fe0), 32'd0);
    check("abort_data_out", 32'(data_out), 32'hFF);
    push_exp(1'b0, 8'h3C); model_dout = 8'h3C;
    send_byte(8'h3C, 1'b1);
    drain(200);
    check("x3c_dv_count", 32'(dv_cnt - dv0), 32'd1);
    check("x3c_data_out", 32'(data_out), 32'h3C);

    // Break: line low for 40 bit periods
    dv0 = dv_cnt; fe0 = fe_cnt;
    for (int i = 0; i < 4; i++) push_exp(1'b1, model_dout);
    rx = 1'b0;
    repeat (40 * CPB) @(posedge clk);
    #1;
    rx = 1'b1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_dout = 8'hFF;
    check("break_fe_count", 32'(fe_cnt - fe0), 32'd4);
    check("break_dv_count", 32'(dv_cnt - dv0), 32'd0);
    drain(0);
    repeat (200) @(posedge clk);
    #1;
    check("break_quiet_fe", 32'(fe_cnt - fe0), 32'd4);
    check("break_quiet_dv", 32'(dv_cnt - dv0), 32'd0);
    check("break_busy_after", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
